// File: rtl/writeback_ctrl.sv
// Writeback-stage sequencer: accepts one instruction per cycle from MEM, holds
// loads until the data-memory response arrives (bounded by a timeout), and counts retires.
module writeback_ctrl #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_dest_sel,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic [1:0]       rd_dest_select,
  output logic [31:0]      load_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic             load_timeout_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] retire_count
);

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready depends only on the state register.
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [1:0] SEL_LOAD     = 2'b11;
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [4:0] pend_rd;
  logic       pend_reg_write;
  logic [1:0] pend_sel;
  logic       accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      pend_rd          <= '0;
      pend_reg_write   <= 1'b0;
      pend_sel         <= '0;
      rf_we            <= 1'b0;
      rf_waddr         <= '0;
      rd_dest_select   <= '0;
      load_data        <= '0;
      load_timeout_err <= 1'b0;
      retire_count     <= '0;
    end else begin
      rf_we <= 1'b0;
      // A timeout set below overrides this clear in the same cycle.
      if (err_clr) load_timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (in_dest_sel != SEL_LOAD || dmem_rvalid) begin
              if (in_dest_sel == SEL_LOAD) load_data <= dmem_rdata;
              rf_we          <= in_reg_write & (in_rd != 5'd0);
              rf_waddr       <= in_rd;
              rd_dest_select <= in_dest_sel;
              retire_count   <= retire_count + CNT_W'(1);
            end else begin
              pend_rd        <= in_rd;
              pend_reg_write <= in_reg_write;
              pend_sel       <= in_dest_sel;
              wait_cnt       <= '0;
              state          <= WAIT_LOAD;
            end
          end
        end

        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            load_data      <= dmem_rdata;
            rf_we          <= pend_reg_write & (pend_rd != 5'd0);
            rf_waddr       <= pend_rd;
            rd_dest_select <= pend_sel;
            retire_count   <= retire_count + CNT_W'(1);
            state          <= IDLE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            load_timeout_err <= 1'b1;
            state            <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level reference model.
module tb_writeback_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic [1:0]  in_dest_sel = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [1:0]  rd_dest_select, rd_dest_select2;
  logic [31:0] load_data, load_data2;
  logic        rf_we, rf_we2;
  logic [4:0]  rf_waddr, rf_waddr2;
  logic        load_timeout_err, load_timeout_err2;
  logic        err_clr = 1'b0;
  logic [31:0] retire_count;
  logic [2:0]  retire_count2;

  int checks = 0;
  int failures = 0;

  writeback_ctrl #(.LOAD_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_dest_sel(in_dest_sel),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_dest_select(rd_dest_select), .load_data(load_data), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .load_timeout_err(load_timeout_err), .err_clr(err_clr),
    .retire_count(retire_count)
  );

  // Narrow-counter instance on the same inputs, used to observe counter wrap.
  writeback_ctrl #(.LOAD_TIMEOUT(TMO), .CNT_W(3)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_dest_sel(in_dest_sel),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_dest_select(rd_dest_select2), .load_data(load_data2), .rf_we(rf_we2),
    .rf_waddr(rf_waddr2), .load_timeout_err(load_timeout_err2), .err_clr(err_clr),
    .retire_count(retire_count2)
  );

  always #5 clk = ~clk;

  // Reference model state: a pending load and the observable outputs.
  bit          m_busy;
  int          m_waits;
  logic [4:0]  p_rd;
  logic        p_rw;
  logic [1:0]  p_sel;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [1:0]  m_sel;
  logic [31:0] m_ldata;
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_waits = 0; p_rd = '0; p_rw = 0; p_sel = '0;
    m_we = 0; m_waddr = '0; m_sel = '0; m_ldata = '0; m_err = 0; m_cnt = '0;
  endtask

  task automatic retire(input logic [4:0] rd, input logic rw, input logic [1:0] sel);
    m_we = rw && (rd != 5'd0);
    m_waddr = rd;
    m_sel = sel;
    m_cnt = m_cnt + 32'd1;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit timed_out = 0;
    m_we = 0;
    if (!m_busy) begin
      if (in_valid) begin
        if (in_dest_sel != 2'b11 || dmem_rvalid) begin
          if (in_dest_sel == 2'b11) m_ldata = dmem_rdata;
          retire(in_rd, in_reg_write, in_dest_sel);
        end else begin
          m_busy = 1; m_waits = 0;
          p_rd = in_rd; p_rw = in_reg_write; p_sel = in_dest_sel;
        end
      end
    end else begin
      m_waits++;
      if (dmem_rvalid) begin
        m_ldata = dmem_rdata;
        retire(p_rd, p_rw, p_sel);
        m_busy = 0;
      end else if (m_waits == TMO) begin
        timed_out = 1;
        m_busy = 0;
      end
    end
    if (err_clr) m_err = 0;
    if (timed_out) m_err = 1;
  endtask

  task automatic check_outputs();
    check("rf_we", 32'(rf_we), 32'(m_we));
    check("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    check("rd_dest_select", 32'(rd_dest_select), 32'(m_sel));
    check("load_data", load_data, m_ldata);
    check("load_timeout_err", 32'(load_timeout_err), 32'(m_err));
    check("retire_count", retire_count, m_cnt);
    check("retire_count_wrap", 32'(retire_count2), 32'(m_cnt[2:0]));
  endtask

  task automatic cycle();
    check("in_ready", 32'(in_ready), 32'(!m_busy));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic [1:0] sel, input logic rv, input logic [31:0] rdata,
                       input logic clr);
    in_valid = v; in_rd = rd; in_reg_write = rw; in_dest_sel = sel;
    dmem_rvalid = rv; dmem_rdata = rdata; err_clr = clr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 5'd0, 0, 2'b00, 0, 32'h0, 0);
      cycle();
    end
  endtask

  initial begin
    model_reset();
    // Reset held: every output at its reset value.
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("in_ready_reset", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    idle_cycles(5);

    // Back-to-back ALU writes.
    for (int i = 5; i <= 7; i++) begin
      drive(1, 5'(i), 1, 2'b00, 0, 32'h0, 0);
      cycle();
    end
    idle_cycles(1);
    check("retire_after_alu", retire_count, 32'd3);

    // Load with the response four cycles after acceptance.
    drive(1, 5'd9, 1, 2'b11, 0, 32'h0, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 5'd0, 0, 2'b00, (i == 3), 32'hDEADBEEF, 0);
      cycle();
    end
    check("load_we", 32'(rf_we), 32'd1);
    check("load_waddr", 32'(rf_waddr), 32'd9);
    check("load_value", load_data, 32'hDEADBEEF);
    check("ready_on_write", 32'(in_ready), 32'd1);

    // Load that is never answered times out.
    drive(1, 5'd3, 1, 2'b11, 0, 32'h0, 0);
    cycle();
    idle_cycles(TMO);
    check("timeout_err", 32'(load_timeout_err), 32'd1);
    check("timeout_no_retire", retire_count, 32'd4);
    drive(0, 5'd0, 0, 2'b00, 0, 32'h0, 1);
    cycle();
    check("err_cleared", 32'(load_timeout_err), 32'd0);

    // Timeout coinciding with err_clr: the flag must still be set.
    drive(1, 5'd4, 1, 2'b11, 0, 32'h0, 0);
    cycle();
    idle_cycles(TMO - 1);
    drive(0, 5'd0, 0, 2'b00, 0, 32'h0, 1);
    cycle();
    check("set_beats_clr", 32'(load_timeout_err), 32'd1);

    // Response on the last permitted wait cycle wins over the timeout.
    drive(1, 5'd12, 1, 2'b11, 0, 32'h0, 1);
    cycle();
    idle_cycles(TMO - 1);
    drive(0, 5'd0, 0, 2'b00, 1, 32'h0BADF00D, 0);
    cycle();
    check("rvalid_beats_timeout", 32'(rf_we), 32'd1);

    // Write to x0 retires without a register-file write.
    drive(1, 5'd0, 1, 2'b10, 0, 32'h0, 0);
    cycle();
    check("x0_no_write", 32'(rf_we), 32'd0);

    // Reset in the middle of a load wait abandons it.
    drive(1, 5'd20, 1, 2'b11, 0, 32'h0, 0);
    cycle();
    idle_cycles(2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 5'd0, 0, 2'b00, 1, 32'h12345678, 0);
    cycle();
    check("no_write_after_rst", 32'(rf_we), 32'd0);

    // Randomized traffic; response likelihood varies so timeouts also occur.
    for (int phase = 0; phase < 4; phase++) begin
      int rv_pct;
      rv_pct = (phase == 1) ? 4 : (phase == 3) ? 90 : 35;
      for (int i = 0; i < 600; i++) begin
        drive($urandom_range(99) < 70, 5'($urandom_range(31)), 1'($urandom_range(1)),
              2'($urandom_range(3)), $urandom_range(99) < rv_pct, $urandom,
              $urandom_range(7) == 0);
        cycle();
      end
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writeback_ctrl.md
Name: writeback_ctrl

Overview:
Sequences the writeback stage of the pipeline. It accepts one instruction per cycle from MEM, drives the writeback mux select, and produces the register-file write enable and address. It holds loads until the data-memory read response arrives, back-pressuring MEM while it waits. It bounds that wait with a timeout and counts retired instructions.

Parameters:
LOAD_TIMEOUT, 16, cycles spent in WAIT_LOAD before the load is abandoned (legal range 1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  writeback can accept this cycle
in_rd  input  5  destination register index
in_reg_write  input  1  instruction writes the register file
in_dest_sel  input  2  00 ALU result, 01 immediate, 10 PC+4, 11 dmem load
dmem_rvalid  input  1  data-memory read response valid
dmem_rdata  input  32  data-memory read data
rd_dest_select  output  2  select to the writeback mux
load_data  output  32  captured load data, feeds the mux dmem input
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write address
load_timeout_err  output  1  sticky load-timeout flag
err_clr  input  1  clears load_timeout_err
retire_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1): state=IDLE; rf_we=0, rf_waddr=0, rd_dest_select=00, load_data=0, load_timeout_err=0, retire_count=0, timeout counter=0. Asserting rst mid-WAIT_LOAD abandons the load with no write.
- in_ready = (state==IDLE). It is combinational from the state register only, with no path from in_valid.
- Accept = in_valid & in_ready. All outputs except in_ready are registered.
- IDLE, accept, in_dest_sel!=11: in the next cycle rf_we=in_reg_write & (in_rd!=0), rf_waddr=in_rd, rd_dest_select=in_dest_sel. Stay in IDLE. Latency is 1 cycle.
- IDLE, accept, in_dest_sel==11, dmem_rvalid=1 in the same cycle: load_data<=dmem_rdata. The write is issued as in the non-load case (1-cycle latency). Stay in IDLE.
- IDLE, accept, in_dest_sel==11, dmem_rvalid=0: latch rd, reg_write and sel. Go to WAIT_LOAD with timeout counter=0. The next cycle has rf_we=0.
- WAIT_LOAD:
  - Each cycle with dmem_rvalid=0, the counter increments.
  - dmem_rvalid=1: capture dmem_rdata, pulse rf_we for the latched instruction next cycle (x0 suppression applies), return to IDLE.
  - Counter reaches LOAD_TIMEOUT-1 with rvalid=0: set load_timeout_err, return to IDLE, no write, no retire.
  - rvalid and timeout in the same cycle: rvalid wins.
- dmem_rvalid while in IDLE with no load accepted that cycle: ignored, no state change.
- rf_we is a single-cycle pulse per write. It is 0 in every cycle without a completion.
- rd_dest_select and rf_waddr hold their last value when rf_we=0.
- x0 rule: in_rd==0 never produces rf_we=1, but the instruction still retires.
- retire_count increments by 1 in the cycle rf_we would be produced, whether or not it was actually written (x0 or reg_write=0). It wraps modulo 2^CNT_W. Timed-out loads do not retire.
- load_timeout_err:
  - Sticky.
  - err_clr=1 clears it next cycle.
  - A timeout and err_clr in the same cycle leave it set (set wins).

Test Plan:
- Reset released, in_valid=0 for 5 cycles -> rf_we=0, in_ready=1, retire_count=0 throughout.
- Back-to-back ALU ops rd=5, 6, 7 (sel=00, reg_write=1) on consecutive cycles -> rf_we=1 on the 3 following cycles, rf_waddr=5, 6, 7, rd_dest_select=00, retire_count=3.
- Load rd=9, rvalid arrives 4 cycles later with rdata=0xDEADBEEF:
  - in_ready=0 for 4 cycles.
  - Then rf_we=1, rf_waddr=9, rd_dest_select=11, load_data=0xDEADBEEF.
  - in_ready=1 on the write cycle.
- Load with LOAD_TIMEOUT=16 and rvalid never asserted -> load_timeout_err=1 after 16 WAIT_LOAD cycles, no rf_we, retire_count unchanged, in_ready returns to 1. Then err_clr=1 -> err=0 next cycle.
- rd=0 with sel=10 and reg_write=1 -> rf_we stays 0, retire_count increments by 1.
- rst asserted mid-WAIT_LOAD, rvalid asserted after rst deasserts -> no rf_we, state IDLE, all outputs at reset values. Separately, retire_count preloaded near 0xFFFFFFFF wraps to 0 after the next retire.
